// File: rtl/bg_mem_pkg.sv
// Shared types and default sizing for the background memory arbiter.
package bg_mem_pkg;

    localparam int DEF_ADDR_W       = 25;
    localparam int DEF_WF_DEPTH     = 4;
    localparam int DEF_RD_BURST_MAX = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/bg_mem_arbiter_if.sv
// Command bus between the arbiter (master) and the SDRAM controller (slave).
interface bg_mem_arbiter_if #(
    parameter int ADDR_W = bg_mem_pkg::DEF_ADDR_W
);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic              mem_we;
    logic              mem_rd;
    logic [15:0]       mem_dout;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_din, mem_we, mem_rd,
        input  mem_dout, mem_ack
    );

    modport slave (
        input  mem_addr, mem_din, mem_we, mem_rd,
        output mem_dout, mem_ack
    );
endinterface

// File: rtl/bg_wr_fifo.sv
// Synchronous write FIFO holding {byte address, byte} download entries.
module bg_wr_fifo
    import bg_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_WF_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [7:0]        push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [7:0]        head_data,
    output logic              full,
    output logic              empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + 8;

    logic [EW-1:0] store_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            store_q[wr_ptr_q] <= {push_addr, push_data};
        end
    end

    assign {head_addr, head_data} = store_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/bg_mem_arbiter.sv
// Shares one SDRAM command port between buffered download writes and pixel-fetch reads.
//   state       | meaning
//   ST_IDLE     | no command outstanding; pick next grant
//   ST_WR_ISSUE | mem_we strobe with FIFO head; head popped
//   ST_WR_WAIT  | write outstanding, waiting for mem_ack
//   ST_RD_ISSUE | mem_rd strobe with read slot address; slot released
//   ST_RD_WAIT  | read outstanding, mem_dout captured on mem_ack
module bg_mem_arbiter
    import bg_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int WF_DEPTH     = DEF_WF_DEPTH,
    parameter int RD_BURST_MAX = DEF_RD_BURST_MAX
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_full,
    output logic              wr_overflow,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data,
    output logic              rd_valid,
    output logic              rd_drop,
    bg_mem_arbiter_if.master  mem
);
    localparam int SW = $clog2(RD_BURST_MAX + 1);
    localparam logic [SW-1:0] BURST_LIM = SW'(RD_BURST_MAX);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_rd_q, mem_rd_d;
    logic [15:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_drop_q, rd_drop_d;
    logic              wr_overflow_q, wr_overflow_d;
    logic              slot_pend_q, slot_pend_d;
    logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
    logic [SW-1:0]     streak_q, streak_d;

    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_W-1:0] head_addr;
    logic [7:0]        head_data;
    logic              wr_grant, rd_grant;

    bg_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (WF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_addr (wr_addr),
        .push_data (wr_data),
        .pop       (fifo_pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A push while full is still taken if the head leaves in the same cycle.
    assign fifo_pop  = (state_q == ST_WR_ISSUE);
    assign fifo_push = wr_req && (!fifo_full || fifo_pop);

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        mem_we_d      = 1'b0;
        mem_rd_d      = 1'b0;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        rd_drop_d     = 1'b0;
        wr_overflow_d = wr_overflow_q | (wr_req && fifo_full && !fifo_pop);
        slot_pend_d   = slot_pend_q;
        slot_addr_d   = slot_addr_q;
        streak_d      = streak_q;
        wr_grant      = 1'b0;
        rd_grant      = 1'b0;

        if (state_q == ST_RD_ISSUE) begin
            slot_pend_d = 1'b0;
        end
        // Once RD_ISSUE is reached the old address is already on the bus, so no drop.
        if (rd_req) begin
            slot_pend_d = 1'b1;
            slot_addr_d = rd_addr;
            rd_drop_d   = slot_pend_q && (state_q != ST_RD_ISSUE);
        end

        case (state_q)
            ST_IDLE: begin
                if (fifo_full) begin
                    wr_grant = 1'b1;
                end else if (slot_pend_q && (streak_q < BURST_LIM)) begin
                    rd_grant = 1'b1;
                end else if (!fifo_empty) begin
                    wr_grant = 1'b1;
                end
            end
            ST_WR_ISSUE: state_d = ST_WR_WAIT;
            ST_RD_ISSUE: state_d = ST_RD_WAIT;
            ST_WR_WAIT: begin
                if (mem.mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (mem.mem_ack) begin
                    state_d    = ST_IDLE;
                    rd_data_d  = mem.mem_dout;
                    rd_valid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_grant) begin
            state_d    = ST_WR_ISSUE;
            mem_we_d   = 1'b1;
            mem_addr_d = head_addr;
            mem_din_d  = head_data;
        end
        // slot_addr_d lets a same-cycle replacement win over the address being granted.
        if (rd_grant) begin
            state_d    = ST_RD_ISSUE;
            mem_rd_d   = 1'b1;
            mem_addr_d = slot_addr_d;
        end

        if (wr_grant || fifo_empty) begin
            streak_d = '0;
        end else if (rd_grant && (streak_q < BURST_LIM)) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_we_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            rd_drop_q     <= 1'b0;
            wr_overflow_q <= 1'b0;
            slot_pend_q   <= 1'b0;
            slot_addr_q   <= '0;
            streak_q      <= '0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_we_q      <= mem_we_d;
            mem_rd_q      <= mem_rd_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            rd_drop_q     <= rd_drop_d;
            wr_overflow_q <= wr_overflow_d;
            slot_pend_q   <= slot_pend_d;
            slot_addr_q   <= slot_addr_d;
            streak_q      <= streak_d;
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_din  = mem_din_q;
    assign mem.mem_we   = mem_we_q;
    assign mem.mem_rd   = mem_rd_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign rd_drop      = rd_drop_q;
    assign wr_full      = fifo_full;
    assign wr_overflow  = wr_overflow_q;

endmodule

// File: tb/tb_bg_mem_arbiter.sv
// Directed bench for bg_mem_arbiter with a small SDRAM controller responder.
module tb_bg_mem_arbiter;
    import bg_mem_pkg::*;

    localparam int AW = 25;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          wr_full, wr_overflow;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [15:0]   rd_data;
    logic          rd_valid, rd_drop;

    bg_mem_arbiter_if #(.ADDR_W(AW)) mem_if ();

    bg_mem_arbiter #(.ADDR_W(AW), .WF_DEPTH(4), .RD_BURST_MAX(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_full     (wr_full),
        .wr_overflow (wr_overflow),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_drop     (rd_drop),
        .mem         (mem_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: cumulative event counts, sampled on the falling edge.
    int            n_rd = 0, n_we = 0, n_valid = 0, n_drop = 0;
    byte unsigned  gq[$];
    logic [AW-1:0] we_addr_q[$];
    logic [7:0]    we_din_q[$];

    always @(negedge clk) begin
        if (mem_if.mem_rd === 1'b1) begin
            n_rd++;
            gq.push_back(8'h52);
        end
        if (mem_if.mem_we === 1'b1) begin
            n_we++;
            gq.push_back(8'h57);
            we_addr_q.push_back(mem_if.mem_addr);
            we_din_q.push_back(mem_if.mem_din);
        end
        if (rd_valid === 1'b1) n_valid++;
        if (rd_drop === 1'b1)  n_drop++;
    end

    // Responder: auto-ack ack_dly cycles after a command, or one manual ack on request.
    logic        ack_en = 1'b0;
    int          ack_dly = 3;
    logic [15:0] resp_data = '0;
    int          man_req = 0;
    logic [15:0] man_data = '0;

    initial begin
        int  cnt;
        int  man_done;
        logic saw;
        cnt      = 0;
        man_done = 0;
        mem_if.mem_ack  = 1'b0;
        mem_if.mem_dout = '0;
        forever begin
            @(negedge clk);
            saw = ack_en && ((mem_if.mem_rd === 1'b1) || (mem_if.mem_we === 1'b1));
            @(posedge clk);
            #1;
            mem_if.mem_ack = 1'b0;
            if (saw) cnt = ack_dly;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_if.mem_ack  = 1'b1;
                    mem_if.mem_dout = resp_data;
                end
            end else if (man_req != man_done) begin
                man_done        = man_req;
                mem_if.mem_ack  = 1'b1;
                mem_if.mem_dout = man_data;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [7:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick(1);
        wr_req  = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        tick(1);
        rd_req  = 1'b0;
    endtask

    // Returns at the falling edge of the mem_rd cycle; cyc=-1 on timeout.
    task automatic wait_rd(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_if.mem_rd === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Returns at the falling edge of the cycle where mem_ack is high.
    task automatic manual_ack(input logic [15:0] d, output int ok);
        man_data = d;
        man_req++;
        ok = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_if.mem_ack === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ok, b_rd, b_we, b_valid, b_drop, b_g;

        // Reset values
        tick(3);
        @(negedge clk);
        check_val("rst_mem_we",   32'(mem_if.mem_we), 32'd0);
        check_val("rst_mem_rd",   32'(mem_if.mem_rd), 32'd0);
        check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_val("rst_rd_drop",  32'(rd_drop), 32'd0);
        check_val("rst_wr_full",  32'(wr_full), 32'd0);
        check_val("rst_wr_ovf",   32'(wr_overflow), 32'd0);
        check_val("rst_mem_addr", 32'(mem_if.mem_addr), 32'd0);
        check_val("rst_mem_din",  32'(mem_if.mem_din), 32'd0);
        check_val("rst_rd_data",  32'(rd_data), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(2);

        // Single read, ack 3 cycles after mem_rd
        ack_en = 1'b1; ack_dly = 3; resp_data = 16'hF0A5;
        b_valid = n_valid;
        rd(25'h10);
        wait_rd(lat);
        check_val("rd_issue_lat", 32'(lat), 32'd2);
        check_val("rd_issue_addr", 32'(mem_if.mem_addr), 32'h10);
        wait_valid(lat);
        check_val("rd_valid_lat", 32'(lat), 32'd4);
        check_val("rd_data", 32'(rd_data), 32'hF0A5);
        tick(5);
        check_val("rd_valid_count", 32'(n_valid - b_valid), 32'd1);
        ack_en = 1'b0;

        // Stray ack while idle is ignored and rd_data holds
        b_valid = n_valid;
        manual_ack(16'h1234, ok);
        tick(3);
        check_val("stray_ack_valid", 32'(n_valid - b_valid), 32'd0);
        check_val("rd_data_hold", 32'(rd_data), 32'hF0A5);

        // Read replaced before issue
        b_rd = n_rd; b_drop = n_drop;
        rd(25'h20);
        rd(25'h24);
        wait_rd(lat);
        check_val("drop_issue_cyc", 32'(lat), 32'd1);
        check_val("drop_issue_addr", 32'(mem_if.mem_addr), 32'h24);
        check_val("drop_strobe", 32'(rd_drop), 32'd1);
        manual_ack(16'h00BE, ok);
        @(negedge clk);
        check_val("drop_rd_valid", 32'(rd_valid), 32'd1);
        check_val("drop_rd_data", 32'(rd_data), 32'h00BE);
        tick(2);
        check_val("drop_count", 32'(n_drop - b_drop), 32'd1);
        check_val("drop_rd_count", 32'(n_rd - b_rd), 32'd1);

        // Fill with read outstanding and no ack: 5th push dropped
        do_reset();
        b_we = n_we;
        rd(25'h30);
        wait_rd(lat);
        tick(1);
        for (int k = 0; k < 5; k++) begin
            push(25'h100 + 25'(k), 8'hA0 + 8'(k));
            check_val($sformatf("fill_full_%0d", k), 32'(wr_full), (k >= 3) ? 32'd1 : 32'd0);
            check_val($sformatf("fill_ovf_%0d", k), 32'(wr_overflow), (k >= 4) ? 32'd1 : 32'd0);
        end
        check_val("fill_count", 32'(dut.u_fifo.count_q), 32'd4);
        check_val("fill_no_we", 32'(n_we - b_we), 32'd0);

        // Push and pop in the same cycle while full
        do_reset();
        b_we = we_addr_q.size(); b_valid = n_valid;
        rd(25'h40);
        wait_rd(lat);
        tick(1);
        for (int k = 0; k < 4; k++) push(25'h200 + 25'(k), 8'hC0 + 8'(k));
        check_val("pp_full_before", 32'(wr_full), 32'd1);
        manual_ack(16'h5A5A, ok);
        lat = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (mem_if.mem_we === 1'b1) begin
                lat = i;
                break;
            end
        end
        check_val("pp_we_cyc", 32'(lat), 32'd2);
        check_val("pp_we_addr", 32'(mem_if.mem_addr), 32'h200);
        check_val("pp_we_din", 32'(mem_if.mem_din), 32'hC0);
        wr_req = 1'b1; wr_addr = 25'h1FF; wr_data = 8'hEE;
        @(posedge clk); #1;
        wr_req = 1'b0;
        check_val("pp_count", 32'(dut.u_fifo.count_q), 32'd4);
        check_val("pp_full", 32'(wr_full), 32'd1);
        check_val("pp_no_ovf", 32'(wr_overflow), 32'd0);
        check_val("pp_rd_data", 32'(rd_data), 32'h5A5A);
        check_val("pp_rd_valid", 32'(n_valid - b_valid), 32'd1);
        manual_ack(16'h0000, ok);
        ack_en = 1'b1; ack_dly = 2;
        tick(30);
        ack_en = 1'b0;
        check_val("pp_we_total", 32'(we_addr_q.size() - b_we), 32'd5);
        check_val("pp_order_1", 32'(we_addr_q[b_we + 1]), 32'h201);
        check_val("pp_order_2", 32'(we_addr_q[b_we + 2]), 32'h202);
        check_val("pp_order_3", 32'(we_addr_q[b_we + 3]), 32'h203);
        check_val("pp_order_4", 32'(we_addr_q[b_we + 4]), 32'h1FF);
        check_val("pp_order_4_din", 32'(we_din_q[b_we + 4]), 32'hEE);
        check_val("pp_drained", 32'(dut.u_fifo.count_q), 32'd0);

        // Read burst limit: 4 read grants then the waiting write
        do_reset();
        ack_en = 1'b1; ack_dly = 1;
        b_g = gq.size(); b_we = we_addr_q.size(); b_drop = n_drop;
        wr_req = 1'b1; wr_addr = 25'h77; wr_data = 8'h3C;
        rd_req = 1'b1; rd_addr = 25'h50;
        tick(1);
        wr_req = 1'b0;
        tick(18);
        rd_req = 1'b0;
        tick(15);
        ack_en = 1'b0;
        check_val("burst_grants", (gq.size() - b_g >= 5) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("burst_grant_%0d", i), 32'(gq[b_g + i]), (i < 4) ? 32'h52 : 32'h57);
        end
        check_val("burst_we_addr", 32'(we_addr_q[b_we]), 32'h77);
        check_val("burst_we_din", 32'(we_din_q[b_we]), 32'h3C);
        check_val("burst_drop_seen", (n_drop > b_drop) ? 32'd1 : 32'd0, 32'd1);

        // Reset during RD_WAIT, late ack afterwards
        do_reset();
        b_rd = n_rd; b_we = n_we; b_valid = n_valid;
        rd_req = 1'b1; rd_addr = 25'h60;
        wr_req = 1'b1; wr_addr = 25'h300; wr_data = 8'h11;
        tick(1);
        rd_req = 1'b0;
        push(25'h301, 8'h22);
        wait_rd(lat);
        check_val("rw_read_first", 32'(lat), 32'd1);
        tick(2);
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        manual_ack(16'hDEAD, ok);
        tick(4);
        check_val("rstw_no_valid", 32'(n_valid - b_valid), 32'd0);
        check_val("rstw_state", 32'(dut.state_q), 32'(ST_IDLE));
        check_val("rstw_fifo_empty", 32'(dut.u_fifo.count_q), 32'd0);
        check_val("rstw_rd_data", 32'(rd_data), 32'd0);
        check_val("rstw_no_reissue", 32'(n_rd - b_rd), 32'd1);
        check_val("rstw_no_write", 32'(n_we - b_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
